// File: rtl/cgra_cfg_loader_if.sv
// CSR request/response bus of the CGRA configuration loader.
//   master : drives address, write data, write enable, request valid and
//            response ready (CPU / CSR fabric side)
//   slave  : drives request ready, read data and response valid (loader side)
interface cgra_cfg_loader_if #(
    parameter int unsigned RegAddrWidth = 32,
    parameter int unsigned RegDataWidth = 64
);
    logic [RegAddrWidth-1:0] csr_addr_i;
    logic [RegDataWidth-1:0] csr_wr_data_i;
    logic                    csr_wr_en_i;
    logic                    csr_req_valid_i;
    logic                    csr_req_ready_o;
    logic [RegDataWidth-1:0] csr_rd_data_o;
    logic                    csr_rsp_valid_o;
    logic                    csr_rsp_ready_i;

    modport master (
        output csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
        input  csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o
    );

    modport slave (
        input  csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
        output csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o
    );
endinterface

// File: rtl/cgra_cfg_loader.sv
// CGRA configuration loader.
// Software writes config words per tile into a small context store through the
// CSR bus (addresses 0..NumTiles-1), then writes CTRL (addr NumTiles) to
// broadcast contexts 0..N to all tiles over per-tile valid/ready ports.
// STATUS (addr NumTiles+1) reads {busy, done, err} and clears done/err.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   csr             CSR request/response bus (slave modport)
//   tile_addr_o     per-tile context index, AW bits per tile
//   tile_data_o     per-tile config word, CfgWidth bits per tile
//   tile_valid_o    per-tile valid, tile_ready_i per-tile ready
//   busy_o          load in progress (LOAD or DONE)
//   load_done_o     one-cycle pulse when the load completes
module cgra_cfg_loader #(
    parameter int unsigned NumTiles     = 16,
    parameter int unsigned KernelSize   = 4,
    parameter int unsigned CfgWidth     = 49,
    parameter int unsigned RegDataWidth = 64,
    parameter int unsigned RegAddrWidth = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    cgra_cfg_loader_if.slave             csr,
    output logic [NumTiles*$clog2(KernelSize)-1:0] tile_addr_o,
    output logic [NumTiles*CfgWidth-1:0] tile_data_o,
    output logic [NumTiles-1:0]          tile_valid_o,
    input  logic [NumTiles-1:0]          tile_ready_i,
    output logic                         busy_o,
    output logic                         load_done_o
);
    localparam int unsigned AW = $clog2(KernelSize);
    localparam int unsigned TW = (NumTiles > 1) ? $clog2(NumTiles) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
    state_e state_q, state_d;

    logic [CfgWidth-1:0]     ctx_q [NumTiles][KernelSize];
    logic [AW-1:0]           wptr_q [NumTiles];
    logic [AW-1:0]           ctx_idx_q, last_q;
    logic [NumTiles-1:0]     mask_q, fire, tile_valid;
    logic                    done_q, err_q, rsp_valid_q;
    logic [RegDataWidth-1:0] rd_data_q, rd_data_d;

    logic          req_ready, req_acc, is_tile, is_ctrl, is_stat, busy;
    logic          tile_wr, ctrl_wr, ctrl_op, stat_rd, start, clr_ptr;
    logic          ctx_done, last_ctx;
    logic [TW-1:0] tidx;
    logic          unused_wdata;

    assign unused_wdata = ^csr.csr_wr_data_i;

    // A new request may enter whenever the response slot is free or draining.
    assign req_ready = !rsp_valid_q || csr.csr_rsp_ready_i;
    assign req_acc   = csr.csr_req_valid_i && req_ready;
    // Full address decode: anything outside the map is a write-ignore/read-zero hole.
    assign is_tile   = csr.csr_addr_i < RegAddrWidth'(NumTiles);
    assign is_ctrl   = csr.csr_addr_i == RegAddrWidth'(NumTiles);
    assign is_stat   = csr.csr_addr_i == RegAddrWidth'(NumTiles + 1);
    assign tidx      = csr.csr_addr_i[TW-1:0];

    assign busy    = state_q != IDLE;
    assign tile_wr = req_acc && csr.csr_wr_en_i && is_tile;
    assign ctrl_wr = req_acc && csr.csr_wr_en_i && is_ctrl;
    assign stat_rd = req_acc && !csr.csr_wr_en_i && is_stat;
    assign ctrl_op = ctrl_wr && (csr.csr_wr_data_i[0] || csr.csr_wr_data_i[1]);
    assign start   = ctrl_wr && csr.csr_wr_data_i[0] && !busy;
    assign clr_ptr = ctrl_wr && csr.csr_wr_data_i[1] && !busy;

    // Context finishes once every tile has either accepted earlier or accepts now.
    assign fire     = tile_valid & tile_ready_i;
    assign ctx_done = (state_q == LOAD) && (&(mask_q | fire));
    assign last_ctx = ctx_idx_q == last_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (ctx_done && last_ctx) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        tile_valid  = '0;
        tile_addr_o = '0;
        tile_data_o = '0;
        if (state_q == LOAD) begin
            for (int i = 0; i < NumTiles; i++) begin
                tile_valid[i]                      = !mask_q[i];
                tile_addr_o[i*AW +: AW]            = ctx_idx_q;
                tile_data_o[i*CfgWidth +: CfgWidth] = ctx_q[i][ctx_idx_q];
            end
        end
    end

    assign tile_valid_o = tile_valid;
    assign busy_o       = busy;
    assign load_done_o  = state_q == DONE;

    // Read mux; tile reads return the most recently written context.
    always_comb begin
        rd_data_d = '0;
        if (!csr.csr_wr_en_i) begin
            if (is_tile)      rd_data_d = RegDataWidth'(ctx_q[tidx][wptr_q[tidx] - AW'(1)]);
            else if (is_stat) rd_data_d = RegDataWidth'({busy, done_q, err_q});
        end
    end

    assign csr.csr_req_ready_o = req_ready;
    assign csr.csr_rsp_valid_o = rsp_valid_q;
    assign csr.csr_rd_data_o   = rd_data_q;

    // Datapath: context store, pointers, load sequencing, sticky flags, response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int t = 0; t < NumTiles; t++) begin
                for (int k = 0; k < KernelSize; k++) ctx_q[t][k] <= '0;
                wptr_q[t] <= '0;
            end
            ctx_idx_q   <= '0;
            last_q      <= '0;
            mask_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            if (req_acc) begin
                rsp_valid_q <= 1'b1;
                rd_data_q   <= rd_data_d;
            end else if (csr.csr_rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end

            if (tile_wr && !busy) begin
                ctx_q[tidx][wptr_q[tidx]] <= csr.csr_wr_data_i[CfgWidth-1:0];
                wptr_q[tidx]              <= wptr_q[tidx] + AW'(1);
            end
            if (clr_ptr) begin
                for (int t = 0; t < NumTiles; t++) wptr_q[t] <= '0;
            end

            // Error set has priority; it cannot coincide with a STATUS read anyway.
            if ((tile_wr || ctrl_op) && busy) err_q <= 1'b1;
            else if (stat_rd)                 err_q <= 1'b0;

            // Completion wins over a same-cycle STATUS clear.
            if (ctx_done && last_ctx) done_q <= 1'b1;
            else if (stat_rd)         done_q <= 1'b0;

            if (start) begin
                ctx_idx_q <= '0;
                mask_q    <= '0;
                last_q    <= csr.csr_wr_data_i[AW+1:2];
            end else if (ctx_done) begin
                mask_q <= '0;
                if (!last_ctx) ctx_idx_q <= ctx_idx_q + AW'(1);
            end else if (state_q == LOAD) begin
                mask_q <= mask_q | fire;
            end
        end
    end
endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Randomized + directed bench for cgra_cfg_loader (4 tiles, 4 contexts, 49-bit words).
// A transaction-level model (arrays of contexts, write pointers, load phase and
// per-tile accepted flags) predicts every output each cycle.
module tb_cgra_cfg_loader;
    localparam int NT = 4, KS = 4, CW = 49, DW = 64, ADW = 32, AW = 2;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    cgra_cfg_loader_if #(.RegAddrWidth(ADW), .RegDataWidth(DW)) csr_bus ();

    logic [NT*AW-1:0] tile_addr_o;
    logic [NT*CW-1:0] tile_data_o;
    logic [NT-1:0]    tile_valid_o, tile_ready_i;
    logic             busy_o, load_done_o;

    cgra_cfg_loader #(
        .NumTiles(NT), .KernelSize(KS), .CfgWidth(CW),
        .RegDataWidth(DW), .RegAddrWidth(ADW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .csr         (csr_bus),
        .tile_addr_o (tile_addr_o),
        .tile_data_o (tile_data_o),
        .tile_valid_o(tile_valid_o),
        .tile_ready_i(tile_ready_i),
        .busy_o      (busy_o),
        .load_done_o (load_done_o)
    );

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CW-1:0] m_ctx [NT][KS];
    int            m_wp [NT];
    bit            m_acc [NT];
    int            m_phase, m_c, m_n;   // phase 0 idle, 1 loading, 2 finished
    bit            m_done, m_err, m_rv;
    logic [DW-1:0] m_rd;

    task automatic m_reset();
        for (int t = 0; t < NT; t++) begin
            for (int k = 0; k < KS; k++) m_ctx[t][k] = '0;
            m_wp[t] = 0; m_acc[t] = 0;
        end
        m_phase = 0; m_c = 0; m_n = 0;
        m_done = 0; m_err = 0; m_rv = 0; m_rd = '0;
    endtask

    task automatic m_check();
        logic [255:0] ev, ea, ed;
        ev = '0; ea = '0; ed = '0;
        chk("busy", busy_o, m_phase != 0);
        chk("load_done", load_done_o, m_phase == 2);
        chk("req_ready", csr_bus.csr_req_ready_o, !m_rv || csr_bus.csr_rsp_ready_i);
        chk("rsp_valid", csr_bus.csr_rsp_valid_o, m_rv);
        if (m_rv) chk("rsp_data", csr_bus.csr_rd_data_o, m_rd);
        if (m_phase == 1) begin
            for (int i = 0; i < NT; i++) begin
                ev[i]           = !m_acc[i];
                ea[i*AW +: AW]  = AW'(m_c);
                ed[i*CW +: CW]  = m_ctx[i][m_c];
            end
        end
        chk("tile_valid", tile_valid_o, ev);
        chk("tile_addr", tile_addr_o, ea);
        chk("tile_data", tile_data_o, ed);
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic m_step();
        logic [31:0] ad;
        logic [DW-1:0] d, rv;
        bit acc, bsy, fin, all;
        ad  = csr_bus.csr_addr_i;
        d   = csr_bus.csr_wr_data_i;
        bsy = m_phase != 0;
        acc = csr_bus.csr_req_valid_i && (!m_rv || csr_bus.csr_rsp_ready_i);
        rv  = '0;
        if (!csr_bus.csr_wr_en_i) begin
            if (ad < NT)          rv = DW'(m_ctx[ad][(m_wp[ad] + KS - 1) % KS]);
            else if (ad == NT + 1) rv = DW'({bsy, m_done, m_err});
        end
        if (acc) begin m_rv = 1; m_rd = rv; end
        else if (csr_bus.csr_rsp_ready_i) m_rv = 0;

        fin = 0;
        if (m_phase == 2) m_phase = 0;
        else if (m_phase == 1) begin
            all = 1;
            for (int i = 0; i < NT; i++) begin
                if (tile_ready_i[i]) m_acc[i] = 1;
                if (!m_acc[i]) all = 0;
            end
            if (all) begin
                for (int i = 0; i < NT; i++) m_acc[i] = 0;
                if (m_c == m_n) begin m_phase = 2; fin = 1; end
                else m_c++;
            end
        end

        if (acc && csr_bus.csr_wr_en_i) begin
            if (ad < NT) begin
                if (bsy) m_err = 1;
                else begin
                    m_ctx[ad][m_wp[ad]] = d[CW-1:0];
                    m_wp[ad] = (m_wp[ad] + 1) % KS;
                end
            end else if (ad == NT) begin
                if (bsy && d[1:0] != 0) m_err = 1;
                else if (!bsy) begin
                    if (d[1]) for (int t = 0; t < NT; t++) m_wp[t] = 0;
                    if (d[0]) begin
                        m_phase = 1; m_c = 0; m_n = int'(d[3:2]);
                        for (int i = 0; i < NT; i++) m_acc[i] = 0;
                    end
                end
            end
        end
        if (acc && !csr_bus.csr_wr_en_i && ad == NT + 1) begin m_done = 0; m_err = 0; end
        if (fin) m_done = 1;
    endtask

    always @(negedge clk_i) begin
        m_check();
        if (!rst_ni) m_reset();
        else m_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic csr_op(input logic [31:0] a, input bit we, input logic [63:0] d,
                          output logic [63:0] rd);
        int k = 0;
        csr_bus.csr_addr_i = a; csr_bus.csr_wr_en_i = we; csr_bus.csr_wr_data_i = d;
        csr_bus.csr_req_valid_i = 1'b1; csr_bus.csr_rsp_ready_i = 1'b1;
        @(negedge clk_i);
        while (!csr_bus.csr_req_ready_o && k < 50) begin k++; @(negedge clk_i); end
        tick();
        csr_bus.csr_req_valid_i = 1'b0;
        @(negedge clk_i);
        while (!csr_bus.csr_rsp_valid_o && k < 50) begin k++; @(negedge clk_i); end
        chk("csr_timeout", k < 50, 1'b1);
        rd = csr_bus.csr_rd_data_o;
        tick();
    endtask

    task automatic wait_idle(output int pulses);
        int k = 0;
        pulses = 0;
        do begin
            @(negedge clk_i);
            pulses += int'(load_done_o);
            k++;
        end while (busy_o && k < 100);
        chk("idle_timeout", k < 100, 1'b1);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] rd;
        int pulses, k;
        m_reset();
        rst_ni = 1'b0;
        csr_bus.csr_addr_i = '0; csr_bus.csr_wr_data_i = '0; csr_bus.csr_wr_en_i = 1'b0;
        csr_bus.csr_req_valid_i = 1'b0; csr_bus.csr_rsp_ready_i = 1'b1;
        tile_ready_i = '0;
        tick(); tick();
        chk("rst_req_ready", csr_bus.csr_req_ready_o, 1'b1);
        rst_ni = 1'b1;
        tick();

        // Context pointer wrap on tile 2.
        for (int i = 0; i < 4; i++) csr_op(2, 1, 64'hA + i, rd);
        csr_op(2, 0, 0, rd);  chk("rd_after_4", rd, 64'hD);
        csr_op(2, 1, 64'hE, rd);
        csr_op(2, 0, 0, rd);  chk("rd_after_wrap", rd, 64'hE);

        // Response back-pressure: request ready low, data held, next request waits.
        csr_bus.csr_addr_i = 2; csr_bus.csr_wr_en_i = 0; csr_bus.csr_req_valid_i = 1;
        csr_bus.csr_rsp_ready_i = 0;
        tick();
        csr_bus.csr_addr_i = NT + 1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk_i);
            chk("stall_req_ready", csr_bus.csr_req_ready_o, 1'b0);
            chk("stall_rsp_data", csr_bus.csr_rd_data_o, 64'hE);
            tick();
        end
        csr_bus.csr_rsp_ready_i = 1;
        @(negedge clk_i);
        chk("unstall_req_ready", csr_bus.csr_req_ready_o, 1'b1);
        tick();
        csr_bus.csr_req_valid_i = 0;
        @(negedge clk_i);
        chk("unstall_rsp_valid", csr_bus.csr_rsp_valid_o, 1'b1);
        chk("unstall_status", csr_bus.csr_rd_data_o, 64'h0);
        tick();

        // Fill every tile after a pointer clear, then a full-speed load of 0..3.
        csr_op(NT, 1, 64'h2, rd);
        for (int t = 0; t < NT; t++)
            for (int c = 0; c < KS; c++) csr_op(t, 1, {$urandom, $urandom}, rd);
        tile_ready_i = 4'hF;
        csr_op(NT, 1, 64'hD, rd);
        wait_idle(pulses);
        chk("done_pulses", pulses, 1);
        csr_op(NT + 1, 0, 0, rd); chk("status_done", rd, 64'h2);
        csr_op(NT + 1, 0, 0, rd); chk("status_clr", rd, 64'h0);

        // Partial readiness: tiles 0,2 accept first, context 1 waits for 1,3.
        tile_ready_i = 4'b0101;
        csr_op(NT, 1, 64'h5, rd);
        tick(); tick();
        tile_ready_i = 4'hF;
        wait_idle(pulses);
        chk("partial_pulses", pulses, 1);
        csr_op(NT + 1, 0, 0, rd); chk("status_partial", rd, 64'h2);

        // Tile write while busy is dropped and flags err.
        tile_ready_i = 4'h0;
        csr_op(NT, 1, 64'hD, rd);
        csr_op(1, 1, 64'h55, rd); chk("busy_wr_rsp", rd, 64'h0);
        csr_op(NT + 1, 0, 0, rd); chk("status_err", rd, 64'h5);
        tile_ready_i = 4'hF;
        wait_idle(pulses);
        csr_op(NT + 1, 0, 0, rd); chk("status_after_err", rd, 64'h2);

        // Reset in the middle of a load, while context 2 is presented.
        csr_op(NT, 1, 64'hD, rd);
        k = 0;
        @(negedge clk_i);
        while (tile_addr_o[AW-1:0] != 2'd1 && k < 50) begin k++; @(negedge clk_i); end
        chk("ctx1_timeout", k < 50, 1'b1);
        tick();
        chk("ctx2_at_reset", tile_addr_o[AW-1:0], 2'd2);
        rst_ni = 1'b0;
        tick();
        chk("rst_valid", tile_valid_o, 4'h0);
        chk("rst_busy", busy_o, 1'b0);
        rst_ni = 1'b1;
        csr_op(NT + 1, 0, 0, rd); chk("rst_status", rd, 64'h0);

        // Random traffic; the model checks every cycle.
        for (int n = 0; n < 4000; n++) begin
            int r;
            rst_ni = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 9);
            case (r)
                4:       csr_bus.csr_addr_i = NT;
                5, 6:    csr_bus.csr_addr_i = NT + 1;
                7:       csr_bus.csr_addr_i = 32'h100 + $urandom_range(0, 5);
                8:       csr_bus.csr_addr_i = NT + 2;
                default: csr_bus.csr_addr_i = $urandom_range(0, NT - 1);
            endcase
            csr_bus.csr_wr_en_i     = $urandom_range(0, 1);
            csr_bus.csr_wr_data_i   = {$urandom, $urandom};
            csr_bus.csr_req_valid_i = $urandom_range(0, 1);
            csr_bus.csr_rsp_ready_i = ($urandom_range(0, 3) != 0);
            tile_ready_i            = 4'($urandom_range(0, 15));
            tick();
        end
        rst_ni = 1'b1;
        csr_bus.csr_req_valid_i = 0; csr_bus.csr_rsp_ready_i = 1; tile_ready_i = 4'hF;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/cgra_cfg_loader.md
CGRA_CFG_LOADER -- requirements
Module: cgra_cfg_loader

Interface
REQ-001 SHALL provide parameter NumTiles, default 16, number of CGRA tiles.
REQ-002 SHALL provide parameter KernelSize, default 4 (power of two, >=2), config contexts per tile; AW = $clog2(KernelSize).
REQ-003 SHALL provide parameter CfgWidth, default 49, config word width (<= RegDataWidth), taken from csr_wr_data_i[CfgWidth-1:0].
REQ-004 SHALL provide parameters RegDataWidth, default 64, and RegAddrWidth, default 32, for CSR data and address widths.
REQ-005 clk_i  input  1  single clock, all logic on rising edge.
REQ-006 rst_ni  input  1  reset, synchronous, active-low.
REQ-007 csr_addr_i  input  RegAddrWidth  CSR address; csr_wr_data_i  input  RegDataWidth  write data; csr_wr_en_i  input  1  1=write, 0=read.
REQ-008 csr_req_valid_i  input  1 / csr_req_ready_o  output  1  request handshake.
REQ-009 csr_rd_data_o  output  RegDataWidth / csr_rsp_valid_o  output  1 / csr_rsp_ready_i  input  1  response channel.
REQ-010 tile_addr_o  output  NumTiles*AW  per-tile context index; tile_data_o  output  NumTiles*CfgWidth  per-tile config word; tile_valid_o  output  NumTiles  per-tile valid; tile_ready_i  input  NumTiles  per-tile ready.
REQ-011 busy_o  output  1  load in progress; load_done_o  output  1  one-cycle pulse at load completion.

Function
REQ-012 Address map SHALL be: 0..NumTiles-1 tile config port; NumTiles = CTRL; NumTiles+1 = STATUS; all other addresses accept writes with no effect and read 0.
REQ-013 csr_req_ready_o SHALL equal !csr_rsp_valid_o || csr_rsp_ready_i; a request is accepted when valid && ready.
REQ-014 Every accepted request (read or write) SHALL raise csr_rsp_valid_o the next cycle, held with stable csr_rd_data_o until rsp_valid && rsp_ready; write responses return 0.
REQ-015 Write to tile address t while idle SHALL store data at context wptr[t] of tile t and increment wptr[t] modulo KernelSize (wrap overwrites context 0).
REQ-016 Read of tile address t SHALL return context (wptr[t]-1) mod KernelSize of tile t, zero-extended.
REQ-017 CTRL write: bit0=1 starts load; bit1=1 clears all wptr to 0; bits [AW+1:2] = last context index N to load (contexts 0..N); bit1 and bit0 together SHALL clear pointers and start in the same cycle.
REQ-018 STATUS read SHALL return {busy, done, err} at bits [2:0]; the read clears done and err (cleared in the acceptance cycle).
REQ-019 Tile writes, pointer clears or starts accepted while busy SHALL be dropped and set err; the response still completes.
REQ-020 FSM states: IDLE, LOAD, DONE. IDLE->LOAD on accepted start (context c=0, accepted mask=0); LOAD->DONE when context N is accepted by all tiles; DONE->IDLE after one cycle.
REQ-021 In LOAD, tile i SHALL drive tile_valid_o[i]=1, tile_addr_o[i]=c, tile_data_o[i]=ctx[i][c] until tile_valid_o[i] && tile_ready_i[i], then deassert valid and set mask[i].
REQ-022 When mask | (valid & ready) is all-ones, c SHALL advance (or finish) in that cycle and mask clears; the next context is presented the following cycle.
REQ-023 Outside LOAD, tile_valid_o, tile_addr_o and tile_data_o SHALL be 0.
REQ-024 busy_o SHALL be 1 in LOAD and DONE; load_done_o SHALL be 1 only in DONE; entering DONE sets sticky done.
REQ-025 A STATUS read and a done-set in the same cycle SHALL leave done=1.

Reset
REQ-026 On rst_ni=0 at a rising edge, all context storage, wptr, mask, c, done, err SHALL be 0, state IDLE, all outputs 0 (csr_req_ready_o=1).
REQ-027 Reset asserted mid-load SHALL abort the load with no further tile_valid_o and no load_done_o.

Verification (NumTiles=4, KernelSize=4, CfgWidth=49)
REQ-028 Write 0x1 to addr 2 four times with 0xA,0xB,0xC,0xD, read addr 2 -> 0xD; fifth write 0xE then read -> 0xE, context 0 = 0xE.
REQ-029 Fill all tiles, CTRL write 0xD (start, N=3), all ready=1 -> contexts 0..3 on consecutive cycles, load_done_o one pulse, STATUS read -> 0b010, second read -> 0b000.
REQ-030 Start with N=1, tile_ready_i=0b0101 for 3 cycles then 0xF -> tiles 0,2 valid drops after 1 cycle, context 1 appears only after tiles 1,3 accept.
REQ-031 Tile write during LOAD -> storage unchanged, STATUS err=1, response still returned.
REQ-032 csr_rsp_ready_i=0 for 5 cycles after a read -> csr_req_ready_o=0, rsp data stable, next request accepted the cycle ready rises.
REQ-033 Reset during LOAD at context 2 -> next cycle all tile_valid_o=0, busy_o=0, STATUS reads 0.
